// File: rtl/riscv_ctrl_pkg.sv
// Shared control encodings for the multicycle RV32I core: FSM states, opcodes and
// datapath select values.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecR,
    StExecI,
    StAluWb,
    StBeq,
    StJal,
    StLui,
    StTrap
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMMEXT    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Unknown opcodes fall into TRAP.
  function automatic state_t decode_op(input logic [6:0] op);
    case (op)
      OP_LW, OP_SW: return StMemAdr;
      OP_R:         return StExecR;
      OP_I:         return StExecI;
      OP_BEQ:       return StBeq;
      OP_JAL:       return StJal;
      OP_LUI:       return StLui;
      default:      return StTrap;
    endcase
  endfunction

endpackage

// File: rtl/retire_counter.sv
// Enable-driven wrapping counter of retired instructions.
module retire_counter #(
  parameter int unsigned COUNT_W = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  output logic [COUNT_W-1:0] o_count
);

  logic [COUNT_W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + COUNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multicycle RV32I core: Moore decode of selects and write
// enables, memory-ready stalls, illegal-opcode trap and retirement count.
module multicycle_main_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               PCUpdate,
  output logic               Branch,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               AdrSrc,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic               halted,
  output logic [COUNT_W-1:0] retired
);

  state_t r_state;
  state_t w_next;
  logic   w_retire;
  logic   w_pc_update, w_branch, w_ir_write, w_reg_write, w_mem_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StFetch;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      StFetch:    if (mem_ready) w_next = StDecode;
      StDecode:   w_next = decode_op(op);
      StMemAdr:   w_next = (op == OP_LW) ? StMemRead : StMemWrite;
      StMemRead:  if (mem_ready) w_next = StMemWb;
      StMemWb:    w_next = StFetch;
      StMemWrite: if (mem_ready) w_next = StFetch;
      StExecR:    w_next = StAluWb;
      StExecI:    w_next = StAluWb;
      StAluWb:    w_next = StFetch;
      StBeq:      w_next = StFetch;
      StJal:      w_next = StAluWb;
      StLui:      w_next = StFetch;
      StTrap:     w_next = StTrap;
      default:    w_next = StFetch;
    endcase
  end

  // JAL passes through ALUWB, so it is counted there exactly once.
  assign w_retire = (w_next == StFetch) &&
                    (r_state inside {StMemWb, StMemWrite, StAluWb, StBeq, StLui});

  always_comb begin
    w_pc_update = 1'b0;
    w_branch    = 1'b0;
    w_ir_write  = 1'b0;
    w_reg_write = 1'b0;
    w_mem_write = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = RES_ALUOUT;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_RD2;
    ALUOp       = ALUOP_ADD;
    unique case (r_state)
      StFetch: begin
        ALUSrcB     = SRCB_FOUR;
        ResultSrc   = RES_ALURESULT;
        w_ir_write  = mem_ready;
        w_pc_update = mem_ready;
      end
      StDecode: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      StMemAdr: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
      end
      StMemRead:  AdrSrc = 1'b1;
      StMemWb: begin
        ResultSrc   = RES_DATA;
        w_reg_write = 1'b1;
      end
      StMemWrite: begin
        AdrSrc      = 1'b1;
        w_mem_write = mem_ready;
      end
      StExecR: begin
        ALUSrcA = SRCA_RD1;
        ALUOp   = ALUOP_FUNCT;
      end
      StExecI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNCT;
      end
      StAluWb:    w_reg_write = 1'b1;
      StBeq: begin
        ALUSrcA  = SRCA_RD1;
        ALUOp    = ALUOP_SUB;
        w_branch = 1'b1;
      end
      StJal: begin
        ALUSrcA     = SRCA_OLDPC;
        ALUSrcB     = SRCB_FOUR;
        w_pc_update = 1'b1;
      end
      StLui: begin
        ResultSrc   = RES_IMMEXT;
        w_reg_write = 1'b1;
      end
      StTrap:  ;
      default: ;
    endcase
  end

  // Reset forces FETCH, whose IRWrite/PCUpdate follow mem_ready, so gate explicitly.
  assign PCUpdate = w_pc_update & ~reset;
  assign Branch   = w_branch & ~reset;
  assign IRWrite  = w_ir_write & ~reset;
  assign RegWrite = w_reg_write & ~reset;
  assign MemWrite = w_mem_write & ~reset;
  assign halted   = (r_state == StTrap);

  retire_counter #(
    .COUNT_W(COUNT_W)
  ) u_retire_counter (
    .i_clk  (clk),
    .i_rst  (reset),
    .i_en   (w_retire),
    .o_count(retired)
  );

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Scoreboard bench: a per-instruction model predicts every write-enable event (cycle, selects,
// retired count); a negedge monitor compares each enable pulse the DUT produces.
module tb_multicycle_main_fsm;

  localparam int unsigned CW = 4;

  localparam logic [6:0] L_LW = 7'b0000011, L_SW = 7'b0100011, L_R = 7'b0110011;
  localparam logic [6:0] L_I = 7'b0010011, L_BEQ = 7'b1100011, L_JAL = 7'b1101111;
  localparam logic [6:0] L_LUI = 7'b0110111;

  // Enable order: {PCUpdate, Branch, IRWrite, RegWrite, MemWrite}
  localparam logic [4:0] WE_PC = 5'b10000, WE_BR = 5'b01000, WE_IR = 5'b00100;
  localparam logic [4:0] WE_RW = 5'b00010, WE_MW = 5'b00001;

  typedef struct packed {
    logic [4:0]    we;
    logic          adr;
    logic [1:0]    res;
    logic [1:0]    srca;
    logic [1:0]    srcb;
    logic [1:0]    aluop;
    logic [CW-1:0] ret;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [6:0]    op = '0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b1;
  logic          PCUpdate, Branch, IRWrite, RegWrite, MemWrite, AdrSrc, halted;
  logic [1:0]    ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [CW-1:0] retired;

  ev_t q_ev[$];
  int  q_cyc[$];
  int  errors = 0;
  int  checks = 0;
  int  cur_cyc = 0;
  int  model_retired = 0;
  ev_t mon_act, mon_exp;
  int  mon_cyc;

  multicycle_main_fsm #(
    .COUNT_W(CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .zero     (zero),
    .mem_ready(mem_ready),
    .PCUpdate (PCUpdate),
    .Branch   (Branch),
    .IRWrite  (IRWrite),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .AdrSrc   (AdrSrc),
    .ResultSrc(ResultSrc),
    .ALUSrcA  (ALUSrcA),
    .ALUSrcB  (ALUSrcB),
    .ALUOp    (ALUOp),
    .halted   (halted),
    .retired  (retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cur_cyc);
    end
  endtask

  function automatic ev_t mk(input logic [4:0] we, input logic adr, input logic [1:0] res,
                             input logic [1:0] a, input logic [1:0] b, input logic [1:0] ao);
    ev_t e;
    e.we = we; e.adr = adr; e.res = res; e.srca = a; e.srcb = b; e.aluop = ao;
    e.ret = CW'(model_retired);
    return e;
  endfunction

  task automatic push(input int cyc, input ev_t e);
    q_cyc.push_back(cyc);
    q_ev.push_back(e);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cur_cyc++;
  endtask

  function automatic bit is_legal(input logic [6:0] o);
    return o inside {L_LW, L_SW, L_R, L_I, L_BEQ, L_JAL, L_LUI};
  endfunction

  // Monitor: every cycle with any write enable must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      mon_act = {PCUpdate, Branch, IRWrite, RegWrite, MemWrite, AdrSrc, ResultSrc, ALUSrcA,
                 ALUSrcB, ALUOp, retired};
      if (mon_act.we != 5'b0) begin
        checks++;
        if (q_ev.size() == 0) begin
          errors++;
          $display("FAIL unexpected_enable: got we=%b at cycle %0d, expected none",
                   mon_act.we, cur_cyc);
        end else begin
          mon_exp = q_ev.pop_front();
          mon_cyc = q_cyc.pop_front();
          if (mon_act !== mon_exp || mon_cyc != cur_cyc) begin
            errors++;
            $display("FAIL event: got cyc=%0d we=%b adr=%b res=%b a=%b b=%b aluop=%b ret=%0d, expected cyc=%0d we=%b adr=%b res=%b a=%b b=%b aluop=%b ret=%0d",
                     cur_cyc, mon_act.we, mon_act.adr, mon_act.res, mon_act.srca, mon_act.srcb,
                     mon_act.aluop, mon_act.ret, mon_cyc, mon_exp.we, mon_exp.adr, mon_exp.res,
                     mon_exp.srca, mon_exp.srcb, mon_exp.aluop, mon_exp.ret);
          end
        end
      end
    end
  end

  // kind: 0 R, 1 I, 2 lw, 3 sw, 4 beq, 5 jal, 6 lui; f fetch stalls, m memory stalls.
  task automatic run_instr(input int kind, input int f, input int m);
    logic [6:0] opc;
    int         plan[$];  // per cycle mem_ready: 0 low, 1 high, 2 random
    int         base;
    base = cur_cyc + 1;
    for (int i = 0; i < f; i++) plan.push_back(0);
    plan.push_back(1);
    plan.push_back(2);
    push(base + f, mk(WE_IR | WE_PC, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00));
    case (kind)
      0, 1: begin
        opc = (kind == 0) ? L_R : L_I;
        plan.push_back(2); plan.push_back(2);
        push(base + f + 3, mk(WE_RW, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00));
      end
      2: begin
        opc = L_LW;
        plan.push_back(2);
        for (int i = 0; i < m; i++) plan.push_back(0);
        plan.push_back(1); plan.push_back(2);
        push(base + f + 4 + m, mk(WE_RW, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00));
      end
      3: begin
        opc = L_SW;
        plan.push_back(2);
        for (int i = 0; i < m; i++) plan.push_back(0);
        plan.push_back(1);
        push(base + f + 3 + m, mk(WE_MW, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00));
      end
      4: begin
        opc = L_BEQ;
        plan.push_back(2);
        push(base + f + 2, mk(WE_BR, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01));
      end
      5: begin
        opc = L_JAL;
        plan.push_back(2); plan.push_back(2);
        push(base + f + 2, mk(WE_PC, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00));
        push(base + f + 3, mk(WE_RW, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00));
      end
      default: begin
        opc = L_LUI;
        plan.push_back(2);
        push(base + f + 2, mk(WE_RW, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00));
      end
    endcase
    model_retired++;
    for (int k = 0; k < plan.size(); k++) begin
      adv();
      op        = (k <= f) ? 7'($urandom) : opc;
      zero      = 1'($urandom);
      mem_ready = (plan[k] == 2) ? 1'($urandom) : 1'(plan[k]);
    end
  endtask

  // Release reset mid-cycle with mem_ready low so the partial cycle is a plain FETCH stall.
  task automatic release_reset();
    #2;
    mem_ready = 1'b0;
    reset     = 1'b0;
  endtask

  initial begin
    logic [6:0] bad;
    #7;
    check("reset_enables", {27'b0, PCUpdate, Branch, IRWrite, RegWrite, MemWrite}, 32'h0);
    check("reset_retired", 32'(retired), 32'h0);
    check("reset_halted", 32'(halted), 32'h0);
    release_reset();

    repeat (40) run_instr($urandom_range(6), $urandom_range(2), $urandom_range(3));
    run_instr(0, 0, 0);
    run_instr(2, 0, 2);
    run_instr(3, 1, 3);
    run_instr(6, 0, 0);
    run_instr(4, 0, 0);
    run_instr(5, 0, 0);

    // Reset during EXECI: no writeback, counter cleared.
    push(cur_cyc + 1, mk(WE_IR | WE_PC, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00));
    adv(); op = 7'($urandom); mem_ready = 1'b1;
    adv(); op = L_I; mem_ready = 1'($urandom);
    adv(); op = L_I; mem_ready = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("execi_reset_regwrite", 32'(RegWrite), 32'h0);
    check("execi_reset_irwrite", 32'(IRWrite), 32'h0);
    check("execi_reset_retired", 32'(retired), 32'h0);
    model_retired = 0;
    @(posedge clk);
    release_reset();
    run_instr(1, 0, 0);
    run_instr(0, 1, 0);

    // Illegal opcode: TRAP absorbs until reset.
    do bad = 7'($urandom); while (is_legal(bad));
    push(cur_cyc + 1, mk(WE_IR | WE_PC, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00));
    adv(); op = 7'($urandom); mem_ready = 1'b1;
    adv(); op = bad; mem_ready = 1'($urandom);
    for (int i = 0; i < 12; i++) begin
      adv();
      op = 7'($urandom);
      mem_ready = 1'($urandom);
      #1;
      check("trap_halted", 32'(halted), 32'h1);
      check("trap_enables", {27'b0, PCUpdate, Branch, IRWrite, RegWrite, MemWrite}, 32'h0);
    end
    reset = 1'b1;
    #1;
    check("trap_reset_halted", 32'(halted), 32'h0);
    model_retired = 0;
    @(posedge clk);
    release_reset();
    run_instr(6, 0, 0);
    run_instr(2, 1, 1);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(q_ev.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
